// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory stage of the vector ASIP pipeline. Executes scalar
//                (1 word) or vector (DATA_W/WORD_W words) loads and stores
//                over a word-wide req/ack data-memory bus. It stalls the
//                upstream stage while an access runs, and it produces the
//                writeback/forwarding result (valid, vf, dest, data).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low

    // Execute-stage interface
    input  logic              in_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              vf_in,
    input  logic [3:0]        dest_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] alu_res_in,

    // Data-memory bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack,

    // Pipeline control and writeback/forwarding
    output logic              stall,
    output logic              res_valid,
    output logic              res_vf,
    output logic [3:0]        res_dest,
    output logic [DATA_W-1:0] res_data
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_LANES   = DATA_W / WORD_W;
    localparam int c_BEAT_W  = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_BYTE_SH = $clog2(WORD_W / 8);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [c_BEAT_W-1:0] beat_q,      beat_d;
    logic [c_BEAT_W-1:0] last_q,      last_d;
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic [DATA_W-1:0]   wbuf_q,      wbuf_d;
    logic [DATA_W-1:0]   lbuf_q,      lbuf_d;
    logic                we_q,        we_d;
    logic                vf_q,        vf_d;
    logic [3:0]          dest_q,      dest_d;
    logic                res_valid_q, res_valid_d;
    logic                res_vf_q,    res_vf_d;
    logic [3:0]          res_dest_q,  res_dest_d;
    logic [DATA_W-1:0]   res_data_q,  res_data_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_in_access;
    logic                w_on_last;
    logic                w_mem_op;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [WORD_W-1:0]   w_beat_wdata;
    logic [DATA_W-1:0]   w_lbuf_merged;
    logic [DATA_W-1:0]   w_scalar_ld;

    assign w_in_access = (state_q == ST_ACCESS);
    assign w_on_last   = (beat_q == last_q);
    assign w_mem_op    = in_valid & (mem_rd | mem_wr);

    // Word address of the current beat; the add wraps naturally at 2^ADDR_W.
    assign w_beat_addr  = base_q + (ADDR_W'(beat_q) << c_BYTE_SH);
    assign w_beat_wdata = wbuf_q[int'(beat_q) * WORD_W +: WORD_W];
    assign w_scalar_ld  = {{(DATA_W - WORD_W){1'b0}}, bus_rdata};

    // Load buffer with the word returned on this beat dropped into its lane,
    // so the final beat's data can go straight into the result register.
    always_comb begin
        w_lbuf_merged = lbuf_q;
        w_lbuf_merged[int'(beat_q) * WORD_W +: WORD_W] = bus_rdata;
    end

    // ------------------------------------------------------------------------
    // Bus and stall outputs: driven only while an access is in flight so the
    // bus reads as all-zero whenever the unit is idle or in reset.
    // ------------------------------------------------------------------------
    assign bus_req   = w_in_access;
    assign bus_we    = w_in_access & we_q;
    assign bus_addr  = w_in_access ? w_beat_addr  : '0;
    assign bus_wdata = w_in_access ? w_beat_wdata : '0;

    // Stall drops in the final-ack cycle so the upstream stage advances on
    // the same edge that retires the access (no bubble between memory ops).
    assign stall = w_in_access ? ~(bus_ack & w_on_last) : w_mem_op;

    assign res_valid = res_valid_q;
    assign res_vf    = res_vf_q;
    assign res_dest  = res_dest_q;
    assign res_data  = res_data_q;

    // Next-state logic: op capture / passthrough in IDLE, beat sequencing in ACCESS
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_d      = last_q;
        base_d      = base_q;
        wbuf_d      = wbuf_q;
        lbuf_d      = lbuf_q;
        we_d        = we_q;
        vf_d        = vf_q;
        dest_d      = dest_q;
        res_valid_d = 1'b0;                 // result valid is a one-cycle pulse
        res_vf_d    = res_vf_q;
        res_dest_d  = res_dest_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_rd || mem_wr) begin
                        // Word-align the base; a load wins if both are set.
                        base_d                  = addr_in;
                        base_d[c_BYTE_SH-1:0]   = '0;
                        wbuf_d                  = wdata_in;
                        vf_d                    = vf_in;
                        dest_d                  = dest_in;
                        we_d                    = mem_wr & ~mem_rd;
                        beat_d                  = '0;
                        last_d                  = vf_in ? c_BEAT_W'(c_LANES - 1) : '0;
                        state_d                 = ST_ACCESS;
                    end else begin
                        res_valid_d = 1'b1;
                        res_vf_d    = vf_in;
                        res_dest_d  = dest_in;
                        res_data_d  = alu_res_in;
                    end
                end
            end

            ST_ACCESS: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        lbuf_d = w_lbuf_merged;
                    end
                    if (!w_on_last) begin
                        beat_d = beat_q + c_BEAT_W'(1);
                    end else begin
                        state_d     = ST_IDLE;
                        res_vf_d    = vf_q;
                        res_dest_d  = dest_q;
                        res_valid_d = ~we_q;
                        if (!we_q) begin
                            res_data_d = vf_q ? w_lbuf_merged : w_scalar_ld;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            last_q      <= '0;
            base_q      <= '0;
            wbuf_q      <= '0;
            lbuf_q      <= '0;
            we_q        <= 1'b0;
            vf_q        <= 1'b0;
            dest_q      <= '0;
            res_valid_q <= 1'b0;
            res_vf_q    <= 1'b0;
            res_dest_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            base_q      <= base_d;
            wbuf_q      <= wbuf_d;
            lbuf_q      <= lbuf_d;
            we_q        <= we_d;
            vf_q        <= vf_d;
            dest_q      <= dest_d;
            res_valid_q <= res_valid_d;
            res_vf_q    <= res_vf_d;
            res_dest_q  <= res_dest_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit. Expected
//                writeback results are queued when an op is driven and are
//                compared when the DUT raises res_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              mem_rd;
    logic              mem_wr;
    logic              vf_in;
    logic [3:0]        dest_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] alu_res_in;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [WORD_W-1:0] bus_wdata;
    logic [WORD_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stall;
    logic              res_valid;
    logic              res_vf;
    logic [3:0]        res_dest;
    logic [DATA_W-1:0] res_data;

    typedef struct packed {
        logic              vf;
        logic [3:0]        dest;
        logic [DATA_W-1:0] data;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .vf_in      (vf_in),
        .dest_in    (dest_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .alu_res_in (alu_res_in),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .stall      (stall),
        .res_valid  (res_valid),
        .res_vf     (res_vf),
        .res_dest   (res_dest),
        .res_data   (res_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 ns after the rising edge, outputs are sampled at +4 ns.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
    endtask

    // Scoreboard: every res_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_res_valid: observed res_dest=%0h res_data=%0h expected no result", res_dest, res_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_res_vf",   res_vf,   mon_e.vf);
                check("sb_res_dest", res_dest, mon_e.dest);
                check("sb_res_data", res_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WORD_W-1:0] vld_data  [4];
        logic [ADDR_W-1:0] wrap_addr [4];
        int occ;

        vld_data  = '{32'h11, 32'h22, 32'h33, 32'h44};
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        rst        = 1'b0;
        idle_in();
        vf_in      = 1'b0;
        dest_in    = '0;
        addr_in    = '0;
        wdata_in   = '0;
        alu_res_in = '0;
        bus_rdata  = '0;
        bus_ack    = 1'b0;

        // ---------------- Reset state ----------------
        next_cycle();
        next_cycle();
        settle();
        check("rst_bus_req",   bus_req,   1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data",  res_data,  '0);
        check("rst_stall",     stall,     1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        settle();
        check("idle_res_valid", res_valid, 1'b0);

        // ---------------- Passthrough, back to back ----------------
        next_cycle();
        in_valid = 1'b1; vf_in = 1'b0; dest_in = 4'd5; alu_res_in = 128'h1234;
        exp_q.push_back('{1'b0, 4'd5, 128'h1234});
        settle();
        check("pt0_stall", stall, 1'b0);
        next_cycle();
        vf_in = 1'b1; dest_in = 4'd9; alu_res_in = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        exp_q.push_back('{1'b1, 4'd9, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978});
        settle();
        check("pt1_stall",     stall,     1'b0);
        check("pt0_res_valid", res_valid, 1'b1);
        next_cycle();
        idle_in();
        settle();
        check("pt1_res_dest", res_dest, 4'd9);

        // ---------------- Vector load, zero-wait bus ----------------
        next_cycle();
        in_valid = 1'b1; mem_rd = 1'b1; vf_in = 1'b1; dest_in = 4'd3;
        addr_in = 32'h100; bus_ack = 1'b1;
        exp_q.push_back('{1'b1, 4'd3, 128'h00000044_00000033_00000022_00000011});
        settle();
        check("vld_capture_stall",   stall,   1'b1);
        check("vld_capture_bus_req", bus_req, 1'b0);
        // Count cycles the op occupies: capture + one per beat up to the
        // final-ack cycle in which stall drops.
        occ = 1;
        do begin
            next_cycle();
            bus_rdata = (occ <= 4) ? vld_data[occ-1] : 32'h0;
            settle();
            if (occ <= 4) begin
                check("vld_bus_addr", bus_addr, 32'h100 + 32'(4 * (occ - 1)));
                check("vld_bus_we",   bus_we,   1'b0);
            end
            occ++;
        end while (stall && occ < 10);
        check("vld_occupancy_cycles", occ, 5);
        next_cycle();
        idle_in();
        bus_ack = 1'b0;
        settle();
        check("vld_bus_req_drop", bus_req, 1'b0);
        check("vld_res_valid",    res_valid, 1'b1);

        // ---------------- Scalar store with wait states ----------------
        next_cycle();
        in_valid = 1'b1; mem_wr = 1'b1; vf_in = 1'b0; dest_in = 4'd7;
        addr_in = 32'h203;
        wdata_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        settle();
        check("sst_capture_stall", stall, 1'b1);
        for (int w = 0; w < 3; w++) begin
            next_cycle();
            settle();
            check("sst_wait_bus_addr",  bus_addr,  32'h200);
            check("sst_wait_bus_we",    bus_we,    1'b1);
            check("sst_wait_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            check("sst_wait_stall",     stall,     1'b1);
        end
        next_cycle();
        bus_ack = 1'b1;
        settle();
        check("sst_ack_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("sst_ack_stall",     stall,     1'b0);
        next_cycle();
        idle_in();
        bus_ack = 1'b0;
        settle();
        check("sst_bus_req_drop", bus_req,   1'b0);
        check("sst_no_res_valid", res_valid, 1'b0);

        // ---------------- Vector store across address wrap ----------------
        next_cycle();
        in_valid = 1'b1; mem_wr = 1'b1; vf_in = 1'b1; dest_in = 4'd1;
        addr_in = 32'hFFFF_FFF8; bus_ack = 1'b1;
        wdata_in = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        settle();
        check("wrap_capture_stall", stall, 1'b1);
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            settle();
            check("wrap_bus_addr",  bus_addr,  wrap_addr[b]);
            check("wrap_bus_wdata", bus_wdata, 32'hA000_0000 + 32'(b));
            check("wrap_stall",     stall,     (b != 3));
        end
        next_cycle();
        idle_in();
        bus_ack = 1'b0;
        settle();
        check("wrap_no_res_valid", res_valid, 1'b0);

        // ---------------- Scalar load (rd+wr both set) then passthrough ----------------
        next_cycle();
        in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1; vf_in = 1'b0; dest_in = 4'd2;
        addr_in = 32'h40; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        exp_q.push_back('{1'b0, 4'd2, 128'hCAFE_F00D});
        settle();
        check("b2b_capture_stall", stall, 1'b1);
        next_cycle();
        settle();
        check("b2b_bus_we_rd_wins", bus_we,   1'b0);
        check("b2b_bus_addr",       bus_addr, 32'h40);
        check("b2b_ack_stall",      stall,    1'b0);
        next_cycle();
        mem_rd = 1'b0; mem_wr = 1'b0; dest_in = 4'd6; alu_res_in = 128'h5555;
        bus_ack = 1'b0;
        exp_q.push_back('{1'b0, 4'd6, 128'h5555});
        settle();
        check("b2b_ld_res_valid", res_valid, 1'b1);
        check("b2b_ld_res_dest",  res_dest,  4'd2);
        check("b2b_pt_stall",     stall,     1'b0);
        next_cycle();
        idle_in();
        settle();
        check("b2b_pt_res_valid", res_valid, 1'b1);
        check("b2b_pt_res_dest",  res_dest,  4'd6);
        next_cycle();
        settle();
        check("b2b_after_res_valid", res_valid, 1'b0);

        // ---------------- Reset in the middle of a vector load ----------------
        next_cycle();
        in_valid = 1'b1; mem_rd = 1'b1; vf_in = 1'b1; dest_in = 4'd4;
        addr_in = 32'h300; bus_ack = 1'b1; bus_rdata = 32'h77;
        wdata_in = {4{32'h5A5A_5A5A}};
        next_cycle();
        next_cycle();
        next_cycle();
        settle();
        check("rstmid_beat2_addr", bus_addr, 32'h308);
        #2;
        rst = 1'b0;
        idle_in();
        #1;
        check("rstmid_bus_req",   bus_req,   1'b0);
        check("rstmid_bus_we",    bus_we,    1'b0);
        check("rstmid_bus_addr",  bus_addr,  '0);
        check("rstmid_bus_wdata", bus_wdata, '0);
        check("rstmid_res_valid", res_valid, 1'b0);
        check("rstmid_res_vf",    res_vf,    1'b0);
        check("rstmid_res_dest",  res_dest,  '0);
        check("rstmid_res_data",  res_data,  '0);
        check("rstmid_stall",     stall,     1'b0);
        next_cycle();
        rst = 1'b1;
        bus_ack = 1'b0;
        next_cycle();
        settle();
        check("post_rst_res_valid", res_valid, 1'b0);
        check("post_rst_bus_req",   bus_req,   1'b0);

        next_cycle();
        next_cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
